// File: rtl/ccg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ccg_pkg                                                         |
// | Desc     : Shared types and width helpers for the crank/cam generator.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package ccg_pkg;

    // Cam window indices are stored wide so out-of-range settings never alias a real tooth.
    localparam int CAM_TW_MAX = 16;

    typedef struct packed {
        logic [CAM_TW_MAX-1:0] start;
        logic [CAM_TW_MAX-1:0] stop;
        logic                  phase;
    } cam_win_t;

    function automatic int ccg_tooth_w(input int teeth);
        return $clog2(teeth);
    endfunction

    // Tick counter must hold the gap top (MISSING+1)*(T+1)-1.
    function automatic int ccg_tcnt_w(input int per_w, input int missing);
        return per_w + $clog2(missing + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ccg_cam_win.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ccg_cam_win                                                     |
// | Desc     : One cam channel; opens/closes its window on tooth changes.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ccg_cam_win
    import ccg_pkg::*;
#(
    parameter int   TOOTH_W  = 6,
    parameter logic CAM_IDLE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_chg,
    input  logic [TOOTH_W-1:0] i_tooth,
    input  logic               i_phase,
    input  cam_win_t           i_win,
    output logic               o_cam
);

    logic [CAM_TW_MAX-1:0] w_tooth_x;
    logic                  r_cam;

    assign w_tooth_x = CAM_TW_MAX'(i_tooth);

    // Stop is tested first so a start==stop window never opens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cam <= CAM_IDLE;
        end else if (i_chg) begin
            if (w_tooth_x == i_win.stop) begin
                r_cam <= CAM_IDLE;
            end else if ((w_tooth_x == i_win.start) && (i_phase == i_win.phase)) begin
                r_cam <= ~CAM_IDLE;
            end
        end
    end

    assign o_cam = r_cam;

endmodule
`default_nettype wire

// File: rtl/crank_cam_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : crank_cam_gen                                                   |
// | Desc     : N-M crank wheel and cam window generator with speed ramp.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module crank_cam_gen
    import ccg_pkg::*;
#(
    parameter int   TEETH    = 60,
    parameter int   MISSING  = 2,
    parameter int   PRESC_W  = 8,
    parameter int   PER_W    = 8,
    parameter int   CAM_CH   = 1,
    parameter logic CAM_IDLE = 1'b1,
    localparam int  TOOTH_W  = ccg_tooth_w(TEETH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_en,
    input  logic [PRESC_W-1:0]        i_presc_top,
    input  logic [PER_W-1:0]          i_per_target,
    input  logic [PER_W-1:0]          i_ramp_step,
    input  logic [CAM_CH*TOOTH_W-1:0] i_cam_start,
    input  logic [CAM_CH*TOOTH_W-1:0] i_cam_stop,
    input  logic [CAM_CH-1:0]         i_cam_phase_sel,
    output logic                      o_vr,
    output logic [CAM_CH-1:0]         o_cam,
    output logic [TOOTH_W-1:0]        o_tooth,
    output logic                      o_cyc_phase,
    output logic                      o_rev_stb
);

    localparam int                  c_tcnt_w = ccg_tcnt_w(PER_W, MISSING);
    localparam logic [TOOTH_W-1:0]  c_last   = TOOTH_W'(TEETH - MISSING - 1);
    localparam logic [c_tcnt_w-1:0] c_mult   = c_tcnt_w'(MISSING + 1);

    logic                r_loaded;
    logic [PRESC_W-1:0]  r_pcnt;
    logic [PRESC_W-1:0]  r_presc;
    logic [c_tcnt_w-1:0] r_tcnt;
    logic [TOOTH_W-1:0]  r_tooth;
    logic                r_vr;
    logic                r_cyc_phase;
    logic                r_rev_stb;
    logic [PER_W-1:0]    r_per_cur;
    cam_win_t            r_win    [CAM_CH];

    cam_win_t            w_win_in [CAM_CH];
    logic [PER_W-1:0]    w_t;
    logic [c_tcnt_w-1:0] w_gap_top;
    logic [c_tcnt_w-1:0] w_top;
    logic [c_tcnt_w-1:0] w_half;
    logic                w_tick;
    logic                w_wrap;
    logic                w_rev;
    logic [TOOTH_W-1:0]  w_tooth_nxt;
    logic                w_phase_nxt;
    logic [PER_W-1:0]    w_per_nxt;

    assign w_t         = (r_per_cur == '0) ? PER_W'(1) : r_per_cur;
    assign w_gap_top   = c_mult * (c_tcnt_w'(w_t) + c_tcnt_w'(1)) - c_tcnt_w'(1);
    assign w_top       = (r_tooth == c_last) ? w_gap_top : c_tcnt_w'(w_t);
    assign w_half      = w_top >> 1;
    assign w_tick      = i_en && r_loaded && (r_pcnt == r_presc);
    assign w_wrap      = w_tick && (r_tcnt == w_top);
    assign w_rev       = w_wrap && (r_tooth == c_last);
    assign w_tooth_nxt = (r_tooth == c_last) ? '0 : r_tooth + TOOTH_W'(1);
    assign w_phase_nxt = r_cyc_phase ^ w_rev;

    always_comb begin
        w_per_nxt = i_per_target;
        if (i_ramp_step != '0) begin
            if (r_per_cur > i_per_target) begin
                if ((r_per_cur - i_per_target) > i_ramp_step) begin
                    w_per_nxt = r_per_cur - i_ramp_step;
                end
            end else if (r_per_cur < i_per_target) begin
                if ((i_per_target - r_per_cur) > i_ramp_step) begin
                    w_per_nxt = r_per_cur + i_ramp_step;
                end
            end
        end
    end

    // per_cur cannot reset to a live input; the first enabled cycle loads it
    // together with the shadows and counting starts on the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loaded    <= 1'b0;
            r_pcnt      <= '0;
            r_presc     <= '0;
            r_tcnt      <= '0;
            r_tooth     <= '0;
            r_vr        <= 1'b0;
            r_cyc_phase <= 1'b0;
            r_rev_stb   <= 1'b0;
            r_per_cur   <= '0;
            for (int c = 0; c < CAM_CH; c++) begin
                r_win[c] <= '0;
            end
        end else begin
            r_rev_stb <= 1'b0;
            if (i_en && !r_loaded) begin
                r_loaded  <= 1'b1;
                r_per_cur <= i_per_target;
                r_presc   <= i_presc_top;
                for (int c = 0; c < CAM_CH; c++) begin
                    r_win[c] <= w_win_in[c];
                end
            end else if (i_en) begin
                r_pcnt <= (r_pcnt == r_presc) ? '0 : r_pcnt + PRESC_W'(1);
                if (w_wrap) begin
                    r_tcnt  <= '0;
                    r_vr    <= 1'b0;
                    r_tooth <= w_tooth_nxt;
                    if (w_rev) begin
                        r_rev_stb   <= 1'b1;
                        r_cyc_phase <= ~r_cyc_phase;
                        r_per_cur   <= w_per_nxt;
                        r_presc     <= i_presc_top;
                        for (int c = 0; c < CAM_CH; c++) begin
                            r_win[c] <= w_win_in[c];
                        end
                    end
                end else if (w_tick) begin
                    r_tcnt <= r_tcnt + c_tcnt_w'(1);
                    if (r_tcnt == w_half) begin
                        r_vr <= 1'b1;
                    end
                end
            end
        end
    end

    generate
        for (genvar c = 0; c < CAM_CH; c++) begin : g_cam
            assign w_win_in[c].start = CAM_TW_MAX'(i_cam_start[c*TOOTH_W +: TOOTH_W]);
            assign w_win_in[c].stop  = CAM_TW_MAX'(i_cam_stop[c*TOOTH_W +: TOOTH_W]);
            assign w_win_in[c].phase = i_cam_phase_sel[c];

            ccg_cam_win #(
                .TOOTH_W  (TOOTH_W),
                .CAM_IDLE (CAM_IDLE)
            ) u_cam_win (
                .clk     (clk),
                .rst     (rst),
                .i_chg   (w_wrap),
                .i_tooth (w_tooth_nxt),
                .i_phase (w_phase_nxt),
                .i_win   (r_win[c]),
                .o_cam   (o_cam[c])
            );
        end
    endgenerate

    assign o_vr        = r_vr;
    assign o_tooth     = r_tooth;
    assign o_cyc_phase = r_cyc_phase;
    assign o_rev_stb   = r_rev_stb;

endmodule
`default_nettype wire

// File: tb/tb_crank_cam_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_crank_cam_gen                                                |
// | Desc     : Directed self-checking bench for crank_cam_gen (60-2, 2 cams).  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_crank_cam_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  presc_top;
    logic [7:0]  per_target;
    logic [7:0]  ramp_step;
    logic [11:0] cam_start;
    logic [11:0] cam_stop;
    logic [1:0]  cam_phase_sel;
    logic        vr;
    logic [1:0]  cam;
    logic [5:0]  tooth;
    logic        cyc_phase;
    logic        rev_stb;

    int checks  = 0;
    int errors  = 0;
    int cam_bad = 0;

    crank_cam_gen #(
        .TEETH    (60),
        .MISSING  (2),
        .PRESC_W  (8),
        .PER_W    (8),
        .CAM_CH   (2),
        .CAM_IDLE (1'b1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_en            (en),
        .i_presc_top     (presc_top),
        .i_per_target    (per_target),
        .i_ramp_step     (ramp_step),
        .i_cam_start     (cam_start),
        .i_cam_stop      (cam_stop),
        .i_cam_phase_sel (cam_phase_sel),
        .o_vr            (vr),
        .o_cam           (cam),
        .o_tooth         (tooth),
        .o_cyc_phase     (cyc_phase),
        .o_rev_stb       (rev_stb)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Ch0 window: teeth 4..53 in odd revolutions only; ch1 has start==stop so stays idle.
    task automatic step();
        logic [1:0] exp_cam;
        @(negedge clk);
        exp_cam = 2'b11;
        if (cyc_phase === 1'b1 && tooth >= 6'd4 && tooth <= 6'd53) exp_cam = 2'b10;
        if (cam !== exp_cam) cam_bad++;
    endtask

    task automatic wait_rev(input string tag, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (rev_stb !== 1'b1 && n < 6000);
        if (rev_stb !== 1'b1) chk({tag, "_timeout"}, 32'(rev_stb), 32'd1);
    endtask

    task automatic wait_tooth(input string tag, input logic [5:0] t);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (tooth !== t && n < 8000);
        if (tooth !== t) chk({tag, "_timeout"}, 32'(tooth), 32'(t));
    endtask

    // Called on the first cycle of a tooth; returns on the first cycle of the next one.
    task automatic run_tooth(output int len, output int hi);
        logic [5:0] t;
        t   = tooth;
        len = 1;
        hi  = (vr === 1'b1) ? 1 : 0;
        forever begin
            step();
            if (tooth !== t || len >= 2000) break;
            len++;
            if (vr === 1'b1) hi++;
        end
    endtask

    initial begin
        int n, len, hi;
        logic snap_vr;
        logic [1:0] snap_cam;

        rst           = 1'b1;
        en            = 1'b0;
        presc_top     = 8'd0;
        per_target    = 8'd63;
        ramp_step     = 8'd0;
        cam_start     = {6'd10, 6'd4};
        cam_stop      = {6'd10, 6'd54};
        cam_phase_sel = 2'b11;
        repeat (3) @(negedge clk);

        chk("rst_vr", 32'(vr), 32'd0);
        chk("rst_cam", 32'(cam), 32'd3);
        chk("rst_tooth", 32'(tooth), 32'd0);
        chk("rst_phase", 32'(cyc_phase), 32'd0);
        chk("rst_rev_stb", 32'(rev_stb), 32'd0);

        // Basic wheel timing
        rst = 1'b0;
        en  = 1'b1;
        wait_rev("rev0", n);
        chk("phase_after_rev0", 32'(cyc_phase), 32'd1);
        run_tooth(len, hi);
        chk("tooth0_len", 32'(len), 32'd64);
        chk("tooth0_hi", 32'(hi), 32'd32);
        wait_tooth("to_t4", 6'd4);
        chk("cam_open_odd", 32'(cam), 32'd2);
        wait_tooth("to_gap", 6'd57);
        run_tooth(len, hi);
        chk("gap_len", 32'(len), 32'd192);
        chk("gap_hi", 32'(hi), 32'd96);
        chk("gap_end_rev_stb", 32'(rev_stb), 32'd1);
        chk("phase_even", 32'(cyc_phase), 32'd0);
        wait_rev("rev_period", n);
        chk("rev_period", 32'(n), 32'd3840);
        chk("cam_model_a", 32'(cam_bad), 32'd0);

        // Ramp 63 -> 31 by 8, requested mid-revolution
        wait_tooth("to_t10", 6'd10);
        per_target = 8'd31;
        ramp_step  = 8'd8;
        run_tooth(len, hi);
        chk("ramp_midrev", 32'(len), 32'd64);
        wait_rev("ramp1", n);
        run_tooth(len, hi);
        chk("ramp_p56", 32'(len), 32'd56);
        wait_rev("ramp2", n);
        run_tooth(len, hi);
        chk("ramp_p48", 32'(len), 32'd48);
        wait_rev("ramp3", n);
        run_tooth(len, hi);
        chk("ramp_p40", 32'(len), 32'd40);
        wait_rev("ramp4", n);
        run_tooth(len, hi);
        chk("ramp_p32", 32'(len), 32'd32);
        wait_rev("ramp5", n);
        run_tooth(len, hi);
        chk("ramp_p32_hold", 32'(len), 32'd32);

        // Freeze for 100 clk in the high half of tooth 0
        wait_rev("en_rev", n);
        len = 1;
        repeat (20) begin
            step();
            len++;
        end
        en       = 1'b0;
        snap_vr  = vr;
        snap_cam = cam;
        repeat (100) begin
            step();
            len++;
        end
        chk("en_vr_hold", 32'(vr), 32'(snap_vr));
        chk("en_vr_high", 32'(vr), 32'd1);
        chk("en_tooth_hold", 32'(tooth), 32'd0);
        chk("en_cam_hold", 32'(cam), 32'(snap_cam));
        en = 1'b1;
        forever begin
            step();
            if (tooth !== 6'd0 || len >= 2000) break;
            len++;
        end
        chk("en_tooth_len", 32'(len), 32'd132);

        // Reset in the middle of the gap
        wait_tooth("rst_gap", 6'd57);
        repeat (10) step();
        rst        = 1'b1;
        per_target = 8'd63;
        ramp_step  = 8'd0;
        step();
        chk("rst2_vr", 32'(vr), 32'd0);
        chk("rst2_tooth", 32'(tooth), 32'd0);
        chk("rst2_cam", 32'(cam), 32'd3);
        chk("rst2_phase", 32'(cyc_phase), 32'd0);
        step();
        rst = 1'b0;
        wait_tooth("rst2_t1", 6'd1);
        run_tooth(len, hi);
        chk("rst2_tooth_len", 32'(len), 32'd64);
        chk("rst2_tooth_hi", 32'(hi), 32'd32);
        wait_rev("rst2_rev0", n);
        wait_rev("rst2_rev1", n);
        chk("rst2_rev_period", 32'(n), 32'd3840);
        chk("cam_model_b", 32'(cam_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
